apb_fabric_reg: RTL
===================

APB_FABRIC_REG -- requirements
Module: apb_fabric_reg

Interface
REQ-001 Parameter N_TGT, default 4, number of APB targets (1..16).
REQ-002 Parameter TGT_BASE, default {32'h9000_0000, 32'h8001_0000, 32'h8000_0000, 32'h0000_0000}, packed N_TGT x 32 base addresses; entry i occupies bits [32*i +: 32].
REQ-003 Parameter TGT_MASK, default {32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'h8000_0000}, packed N_TGT x 32 decode masks.
REQ-004 Parameter TIMEOUT, default 256, maximum number of ACCESS cycles per target transfer; 0 disables the timeout.
REQ-005 Ports clk (input, 1, clock) and rst_n (input, 1, reset): one clock; reset is synchronous and active-low.
REQ-006 Core side (inputs): core_i_psel 1, core_i_penable 1, core_i_paddr 32, core_i_pwrite 1, core_i_pwdata 32, core_i_pwstrb 4.
REQ-007 Core side (outputs): core_i_pready 1, core_i_prdata 32, core_i_pslverr 1.
REQ-008 Target side (outputs): tgt_psel N_TGT, tgt_penable N_TGT, tgt_paddr 32 (offset = paddr & ~mask), tgt_pwrite 1, tgt_pwdata 32, tgt_pwstrb 4.
REQ-009 Target side (inputs): tgt_pready N_TGT, tgt_pslverr N_TGT, tgt_prdata N_TGT*32 (target i at [32*i +: 32]).
REQ-010 Status output: timeout_o 1, a single-cycle pulse when a transfer is aborted.

Function
REQ-011 Target i SHALL match when (core_i_paddr & TGT_MASK[i]) == TGT_BASE[i]; on multiple matches the lowest index wins.
REQ-012 FSM states: IDLE, T_SETUP, T_ACCESS, RESP.
REQ-013 IDLE with core_i_psel=1: register addr offset, pwrite, pwdata, pwstrb and the one-hot target select; go to T_SETUP on a hit, or to RESP with error on a miss.
REQ-014 T_SETUP: the selected tgt_psel=1, tgt_penable=0; go to T_ACCESS unconditionally.
REQ-015 T_ACCESS: tgt_psel=1, tgt_penable=1; when the selected tgt_pready=1, register prdata and pslverr and go to RESP.
REQ-016 RESP: core_i_pready=1 for exactly one cycle with the registered prdata/pslverr; tgt_psel=0; then go to IDLE.
REQ-017 core_i_pready SHALL be 0 in every state except RESP.
REQ-018 Minimum latency: a hit capture in cycle 0 gives core_i_pready in cycle 3; a decode miss gives core_i_pready in cycle 1.
REQ-019 Decode miss response: core_i_pslverr=1, core_i_prdata=0; no tgt_psel is asserted.
REQ-020 Timeout counter: cleared on entry to T_ACCESS and incremented each T_ACCESS cycle with pready=0.
REQ-021 Timeout abort (TIMEOUT>0, count reaches TIMEOUT-1 with pready=0): drop tgt_psel/tgt_penable next cycle; go to RESP with pslverr=1, prdata=0; timeout_o=1 for one cycle.
REQ-022 Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.
REQ-023 pready arriving in the same cycle as the timeout threshold SHALL take precedence: normal response, no timeout_o.
REQ-024 A back-to-back request sampled in the IDLE cycle following RESP SHALL be accepted; there are no idle bubbles beyond the IDLE cycle itself.
REQ-025 Target-side request outputs SHALL be sourced from registers and remain stable from T_SETUP through the end of T_ACCESS.
REQ-026 core_i_prdata SHALL hold its last value outside RESP; the bench checks it only while core_i_pready=1.

Reset
REQ-027 While rst_n=0 at a clk edge: FSM to IDLE; all tgt_psel/tgt_penable, core_i_pready, core_i_pslverr, timeout_o to 0; core_i_prdata, tgt_paddr, tgt_pwdata, tgt_pwstrb to 0; counter to 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no response to the core; tgt_psel is 0 from the cycle after the reset edge.

Structure
REQ-029 Package apb_fabric_pkg: FSM state enum, default base/mask constants for the RAM/UART/MTIMER/PLIC map.
REQ-030 Response selection SHALL reuse the existing one_hot_mux sub-module (CH_N=N_TGT, PLD_W=34).

Verification
REQ-031 Read to 0x0000_0010, RAM target pready immediate, prdata=0xDEAD_BEEF -> core_i_pready in cycle 3, prdata=0xDEAD_BEEF, pslverr=0, tgt_paddr=0x10.
REQ-032 Write to 0x8000_0004, pwdata=0x55, pwstrb=4'b0001, UART pready after 5 wait cycles -> only tgt_psel[1] asserted, tgt_paddr=0x004, response in cycle 8.
REQ-033 Access to 0xA000_0000 (unmapped) -> core_i_pready=1 and pslverr=1 in cycle 1; all tgt_psel stay 0.
REQ-034 TIMEOUT=8, PLIC pready held 0 -> tgt_psel drops after 8 ACCESS cycles; one timeout_o pulse; pslverr=1, prdata=0.
REQ-035 TIMEOUT=8, pready=1 on the 8th ACCESS cycle -> normal response, timeout_o stays 0.
REQ-036 rst_n=0 during T_ACCESS -> all outputs 0 next cycle; a new request after reset completes normally.

Source files
------------

// File: rtl/apb_fabric_pkg.sv
// Shared types and default address map for the APB fabric register slice.
// Targets: 0 RAM, 1 UART, 2 MTIMER, 3 PLIC.
package apb_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        T_SETUP  = 2'd1,
        T_ACCESS = 2'd2,
        RESP     = 2'd3
    } fab_state_t;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK    = 32'h8000_0000;
    localparam logic [31:0] UART_BASE   = 32'h8000_0000;
    localparam logic [31:0] UART_MASK   = 32'hFFFF_F000;
    localparam logic [31:0] MTIMER_BASE = 32'h8001_0000;
    localparam logic [31:0] MTIMER_MASK = 32'hFFFF_0000;
    localparam logic [31:0] PLIC_BASE   = 32'h9000_0000;
    localparam logic [31:0] PLIC_MASK   = 32'hFC00_0000;

    localparam int DEF_N_TGT = 4;
    localparam logic [DEF_N_TGT*32-1:0] DEF_TGT_BASE = {PLIC_BASE, MTIMER_BASE, UART_BASE, RAM_BASE};
    localparam logic [DEF_N_TGT*32-1:0] DEF_TGT_MASK = {PLIC_MASK, MTIMER_MASK, UART_MASK, RAM_MASK};

    // Response payload per target: {pready, pslverr, prdata}
    localparam int RSP_W = 34;

endpackage

// File: rtl/one_hot_mux.sv
// AND-OR multiplexer steered by a one-hot select vector.
// Latency: combinational.
// Backpressure: none; pure datapath.
module one_hot_mux #(
    parameter int CH_N  = 4,
    parameter int PLD_W = 34
) (
    input  logic [CH_N-1:0]       sel,
    input  logic [CH_N*PLD_W-1:0] pld_dat,
    output logic [PLD_W-1:0]      out_dat
);

    always_comb begin
        out_dat = '0;
        for (int i = 0; i < CH_N; i++) begin
            if (sel[i]) begin
                out_dat = out_dat | pld_dat[PLD_W*i +: PLD_W];
            end
        end
    end

endmodule

// File: rtl/apb_fabric_reg.sv
// Registered APB 1-to-N fabric: address decode, target handshake, access timeout.
// Latency: hit response 3 cycles after capture (plus target wait states), decode miss 1 cycle.
// Backpressure: core_i_pready is held low until the target answers or the access times out.
module apb_fabric_reg
    import apb_fabric_pkg::*;
#(
    parameter int                    N_TGT    = 4,
    parameter logic [N_TGT*32-1:0]   TGT_BASE = DEF_TGT_BASE,
    parameter logic [N_TGT*32-1:0]   TGT_MASK = DEF_TGT_MASK,
    parameter int                    TIMEOUT  = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_i_psel,
    input  logic                  core_i_penable,
    input  logic [31:0]           core_i_paddr,
    input  logic                  core_i_pwrite,
    input  logic [31:0]           core_i_pwdata,
    input  logic [3:0]            core_i_pwstrb,
    output logic                  core_i_pready,
    output logic [31:0]           core_i_prdata,
    output logic                  core_i_pslverr,
    output logic [N_TGT-1:0]      tgt_psel,
    output logic [N_TGT-1:0]      tgt_penable,
    output logic [31:0]           tgt_paddr,
    output logic                  tgt_pwrite,
    output logic [31:0]           tgt_pwdata,
    output logic [3:0]            tgt_pwstrb,
    input  logic [N_TGT-1:0]      tgt_pready,
    input  logic [N_TGT-1:0]      tgt_pslverr,
    input  logic [N_TGT*32-1:0]   tgt_prdata,
    output logic                  timeout_o
);

    localparam int               CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int               TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = TIMEOUT[CNT_W-1:0];
    localparam bit               TO_EN     = (TIMEOUT > 0);

    fab_state_t             state, state_nxt;
    logic [N_TGT-1:0]       hit_sel;
    logic [31:0]            hit_mask;
    logic                   hit;
    logic [N_TGT-1:0]       sel_q;
    logic [CNT_W-1:0]       to_cnt;
    logic [N_TGT*RSP_W-1:0] rsp_pld;
    logic [RSP_W-1:0]       rsp_dat;
    logic                   sel_rdy;
    logic                   sel_err;
    logic [31:0]            sel_rdata;
    logic                   to_hit;

    // The core holds psel through the transfer, so the setup/access phase is not needed here.
    logic unused_penable;
    assign unused_penable = core_i_penable;

    // Walk from the highest index down so the lowest matching target wins.
    always_comb begin
        hit_sel  = '0;
        hit_mask = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((core_i_paddr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
                hit_mask   = TGT_MASK[32*i +: 32];
            end
        end
    end

    assign hit = |hit_sel;

    always_comb begin
        rsp_pld = '0;
        for (int i = 0; i < N_TGT; i++) begin
            rsp_pld[RSP_W*i +: RSP_W] = {tgt_pready[i], tgt_pslverr[i], tgt_prdata[32*i +: 32]};
        end
    end

    one_hot_mux #(
        .CH_N  (N_TGT),
        .PLD_W (RSP_W)
    ) u_rsp_mux (
        .sel     (sel_q),
        .pld_dat (rsp_pld),
        .out_dat (rsp_dat)
    );

    assign {sel_rdy, sel_err, sel_rdata} = rsp_dat;
    // A ready target in the threshold cycle beats the timeout.
    assign to_hit = TO_EN && (to_cnt == TO_LAST) && !sel_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (core_i_psel) state_nxt = hit ? T_SETUP : RESP;
            T_SETUP:  state_nxt = T_ACCESS;
            T_ACCESS: if (sel_rdy || to_hit) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q          <= '0;
            tgt_psel       <= '0;
            tgt_penable    <= '0;
            tgt_paddr      <= '0;
            tgt_pwrite     <= 1'b0;
            tgt_pwdata     <= '0;
            tgt_pwstrb     <= '0;
            core_i_pready  <= 1'b0;
            core_i_prdata  <= '0;
            core_i_pslverr <= 1'b0;
            timeout_o      <= 1'b0;
            to_cnt         <= '0;
        end else begin
            core_i_pready <= (state_nxt == RESP);
            timeout_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_i_psel) begin
                        sel_q      <= hit_sel;
                        tgt_psel   <= hit_sel;
                        tgt_paddr  <= core_i_paddr & ~hit_mask;
                        tgt_pwrite <= core_i_pwrite;
                        tgt_pwdata <= core_i_pwdata;
                        tgt_pwstrb <= core_i_pwstrb;
                        if (!hit) begin
                            core_i_prdata  <= '0;
                            core_i_pslverr <= 1'b1;
                        end
                    end
                end
                T_SETUP: begin
                    tgt_penable <= sel_q;
                    to_cnt      <= '0;
                end
                T_ACCESS: begin
                    if (sel_rdy) begin
                        core_i_prdata  <= sel_rdata;
                        core_i_pslverr <= sel_err;
                        tgt_psel       <= '0;
                        tgt_penable    <= '0;
                    end else if (to_hit) begin
                        core_i_prdata  <= '0;
                        core_i_pslverr <= 1'b1;
                        timeout_o      <= 1'b1;
                        tgt_psel       <= '0;
                        tgt_penable    <= '0;
                    end else if (to_cnt != CNT_MAX) begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
